// File: rtl/line_scan_scheduler_if.sv
// Bundle between the pixel source, the segment table writer and the
// shared line detector; the scheduler sits on the slave side.
interface line_scan_scheduler_if #(
  parameter int WIDTH    = 5,
  parameter int SEG_BITS = 2
);
  localparam int SEGMENTS = 2 ** SEG_BITS;

  logic                in_wr_en;
  logic [SEG_BITS-1:0] in_wr_idx;
  logic [WIDTH-1:0]    in_wr_ax;
  logic [WIDTH-1:0]    in_wr_ay;
  logic [WIDTH-1:0]    in_wr_cx;
  logic [WIDTH-1:0]    in_wr_cy;
  logic                in_wr_enable;
  logic                in_wr_segment;

  logic                in_q_valid;
  logic                out_q_ready;
  logic [WIDTH-1:0]    in_q_x;
  logic [WIDTH-1:0]    in_q_y;

  logic                out_r_valid;
  logic                in_r_ready;
  logic                out_r_hit;
  logic [SEG_BITS-1:0] out_r_idx;
  logic [SEGMENTS-1:0] out_r_mask;

  logic [WIDTH-1:0]    out_det_ax;
  logic [WIDTH-1:0]    out_det_ay;
  logic [WIDTH-1:0]    out_det_bx;
  logic [WIDTH-1:0]    out_det_by;
  logic [WIDTH-1:0]    out_det_cx;
  logic [WIDTH-1:0]    out_det_cy;
  logic                out_det_segment;
  logic                in_det_result;

  modport slave (
    input  in_wr_en, in_wr_idx,
    input  in_wr_ax, in_wr_ay,
    input  in_wr_cx, in_wr_cy,
    input  in_wr_enable, in_wr_segment,
    input  in_q_valid, in_q_x, in_q_y,
    output out_q_ready,
    output out_r_valid,
    input  in_r_ready,
    output out_r_hit, out_r_idx, out_r_mask,
    output out_det_ax, out_det_ay,
    output out_det_bx, out_det_by,
    output out_det_cx, out_det_cy,
    output out_det_segment,
    input  in_det_result
  );

  modport master (
    output in_wr_en, in_wr_idx,
    output in_wr_ax, in_wr_ay,
    output in_wr_cx, in_wr_cy,
    output in_wr_enable, in_wr_segment,
    output in_q_valid, in_q_x, in_q_y,
    input  out_q_ready,
    input  out_r_valid,
    output in_r_ready,
    input  out_r_hit, out_r_idx, out_r_mask,
    input  out_det_ax, out_det_ay,
    input  out_det_bx, out_det_by,
    input  out_det_cx, out_det_cy,
    input  out_det_segment,
    output in_det_result
  );
endinterface

// File: rtl/line_scan_scheduler.sv
// Walks a small segment table through one shared line detector per
// queried pixel and returns a per-segment hit mask on valid/ready.
module line_scan_scheduler #(
  parameter int WIDTH    = 5,
  parameter int SEG_BITS = 2
) (
  input logic                 in_clk,
  input logic                 in_reset,
  line_scan_scheduler_if.slave bus
);
  localparam int SEGMENTS = 2 ** SEG_BITS;

  typedef struct packed {
    logic [WIDTH-1:0] ax;
    logic [WIDTH-1:0] ay;
    logic [WIDTH-1:0] cx;
    logic [WIDTH-1:0] cy;
    logic             enable;
    logic             segment;
  } seg_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  seg_t                tbl [SEGMENTS];
  seg_t                cur;
  logic [SEG_BITS-1:0] cnt;
  logic [SEGMENTS-1:0] mask;
  logic [WIDTH-1:0]    bx;
  logic [WIDTH-1:0]    by;
  logic                accept;
  logic                scan;
  logic                last;
  logic [SEG_BITS-1:0] idx;

  assign cur  = tbl[cnt];
  assign last = (cnt == SEG_BITS'(SEGMENTS - 1));

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    accept          = 1'b0;
    scan            = 1'b0;
    bus.out_q_ready = 1'b0;
    bus.out_r_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.out_q_ready = 1'b1;
        if (bus.in_q_valid) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        scan = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.out_r_valid = 1'b1;
        if (bus.in_r_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Table writes never stall; a scan reads the pre-edge content.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      for (int k = 0; k < SEGMENTS; k++) begin
        tbl[k] <= '0;
      end
    end else if (bus.in_wr_en) begin
      tbl[bus.in_wr_idx] <= '{
        ax:      bus.in_wr_ax,
        ay:      bus.in_wr_ay,
        cx:      bus.in_wr_cx,
        cy:      bus.in_wr_cy,
        enable:  bus.in_wr_enable,
        segment: bus.in_wr_segment
      };
    end
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      cnt  <= '0;
      mask <= '0;
      bx   <= '0;
      by   <= '0;
    end else if (accept) begin
      cnt  <= '0;
      mask <= '0;
      bx   <= bus.in_q_x;
      by   <= bus.in_q_y;
    end else if (scan) begin
      mask[cnt] <= cur.enable & bus.in_det_result;
      cnt       <= cnt + 1'b1;
    end
  end

  always_comb begin
    idx = '0;
    for (int k = SEGMENTS - 1; k >= 0; k--) begin
      if (mask[k]) idx = SEG_BITS'(k);
    end
  end

  assign bus.out_r_mask = mask;
  assign bus.out_r_hit  = |mask;
  assign bus.out_r_idx  = idx;

  assign bus.out_det_ax      = cur.ax;
  assign bus.out_det_ay      = cur.ay;
  assign bus.out_det_bx      = bx;
  assign bus.out_det_by      = by;
  assign bus.out_det_cx      = cur.cx;
  assign bus.out_det_cy      = cur.cy;
  assign bus.out_det_segment = cur.segment;
endmodule

// File: tb/tb_line_scan_scheduler.sv
// Self-checking bench: behavioural detector plus a table-level model
// of what each query should return.
module tb_line_scan_scheduler;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  line_scan_scheduler_if #(.WIDTH(5), .SEG_BITS(2)) bus ();

  line_scan_scheduler #(.WIDTH(5), .SEG_BITS(2)) dut (
    .in_clk  (clk),
    .in_reset(rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ax;
    int ay;
    int cx;
    int cy;
    bit en;
    bit seg;
  } ent_t;

  ent_t m_tbl [4];

  function automatic bit det_fn(int ax, int ay, int bx, int by,
                                int cx, int cy, bit seg);
    int  cr;
    bit  on;
    cr = (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
    on = (cr == 0);
    if (seg) begin
      if (bx < ((ax < cx) ? ax : cx)) on = 0;
      if (bx > ((ax > cx) ? ax : cx)) on = 0;
      if (by < ((ay < cy) ? ay : cy)) on = 0;
      if (by > ((ay > cy) ? ay : cy)) on = 0;
    end
    return on;
  endfunction

  assign bus.in_det_result = det_fn(
    int'(bus.out_det_ax), int'(bus.out_det_ay),
    int'(bus.out_det_bx), int'(bus.out_det_by),
    int'(bus.out_det_cx), int'(bus.out_det_cy),
    bus.out_det_segment);

  function automatic logic [3:0] model_mask(int x, int y);
    logic [3:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      m[k] = m_tbl[k].en && det_fn(m_tbl[k].ax, m_tbl[k].ay, x, y,
                                   m_tbl[k].cx, m_tbl[k].cy,
                                   m_tbl[k].seg);
    end
    return m;
  endfunction

  function automatic logic [1:0] lowest(logic [3:0] m);
    for (int k = 0; k < 4; k++) begin
      if (m[k]) return 2'(k);
    end
    return 2'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(int idx, int ax, int ay, int cx, int cy,
                          bit en, bit seg);
    bus.in_wr_en      = 1'b1;
    bus.in_wr_idx     = 2'(idx);
    bus.in_wr_ax      = 5'(ax);
    bus.in_wr_ay      = 5'(ay);
    bus.in_wr_cx      = 5'(cx);
    bus.in_wr_cy      = 5'(cy);
    bus.in_wr_enable  = en;
    bus.in_wr_segment = seg;
  endtask

  task automatic model_wr(int idx, int ax, int ay, int cx, int cy,
                          bit en, bit seg);
    m_tbl[idx] = '{ax: ax, ay: ay, cx: cx, cy: cy, en: en, seg: seg};
  endtask

  task automatic wr(int idx, int ax, int ay, int cx, int cy,
                    bit en, bit seg);
    drive_wr(idx, ax, ay, cx, cy, en, seg);
    step();
    bus.in_wr_en = 1'b0;
    model_wr(idx, ax, ay, cx, cy, en, seg);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_tbl[k] = '{ax: 0, ay: 0, cx: 0, cy: 0, en: 0, seg: 0};
    end
  endtask

  task automatic accept_query(int x, int y);
    int n;
    n = 0;
    while (!bus.out_q_ready && n < 20) begin
      step();
      n++;
    end
    bus.in_q_valid = 1'b1;
    bus.in_q_x     = 5'(x);
    bus.in_q_y     = 5'(y);
    step();
    bus.in_q_valid = 1'b0;
  endtask

  task automatic run_query(input int x, input int y, input int hold,
                           output int lat, output logic [3:0] m,
                           output logic h, output logic [1:0] i,
                           output logic rdy_after);
    bus.in_r_ready = (hold == 0);
    accept_query(x, y);
    lat = 0;
    while (!bus.out_r_valid && lat < 20) begin
      step();
      lat++;
    end
    m = bus.out_r_mask;
    h = bus.out_r_hit;
    i = bus.out_r_idx;
    repeat (hold) step();
    bus.in_r_ready = 1'b1;
    step();
    rdy_after = bus.out_q_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    step();
    total++;
    if ({bus.out_q_ready, bus.out_r_valid, bus.out_r_hit,
         bus.out_r_idx, bus.out_r_mask} !== 9'b1_0_0_00_0000) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b vld=%b hit=%b idx=%0d mask=%b want 1 0 0 0 0000",
               bus.out_q_ready, bus.out_r_valid, bus.out_r_hit,
               bus.out_r_idx, bus.out_r_mask);
    end
    total++;
    if ({bus.out_det_ax, bus.out_det_ay, bus.out_det_bx,
         bus.out_det_by, bus.out_det_cx, bus.out_det_cy,
         bus.out_det_segment} !== 31'd0) begin
      bad++;
      $display("FAIL reset_det got ax=%0d ay=%0d bx=%0d by=%0d cx=%0d cy=%0d seg=%b want all 0",
               bus.out_det_ax, bus.out_det_ay, bus.out_det_bx,
               bus.out_det_by, bus.out_det_cx, bus.out_det_cy,
               bus.out_det_segment);
    end
    rst = 1'b0;
    model_clear();
    step();
  endtask

  task automatic test_single_hit();
    int lat;
    logic [3:0] m;
    logic h, r;
    logic [1:0] i;
    wr(0, 0, 0, 10, 10, 1, 1);
    run_query(5, 5, 0, lat, m, h, i, r);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL single_latency got %0d want 4", lat);
    end
    total++;
    if ({m, h, i} !== {4'b0001, 1'b1, 2'd0}) begin
      bad++;
      $display("FAIL single_result got mask=%b hit=%b idx=%0d want 0001 1 0",
               m, h, i);
    end
    total++;
    if (r !== 1'b1) begin
      bad++;
      $display("FAIL single_ready_after got %b want 1", r);
    end
  endtask

  task automatic test_priority();
    int lat;
    logic [3:0] m;
    logic h, r;
    logic [1:0] i;
    wr(1, 2, 3, 20, 3, 1, 1);
    run_query(4, 3, 0, lat, m, h, i, r);
    total++;
    if ({m, i} !== {4'b0010, 2'd1}) begin
      bad++;
      $display("FAIL prio_one got mask=%b idx=%0d want 0010 1", m, i);
    end
    wr(2, 4, 0, 4, 20, 1, 1);
    run_query(4, 3, 0, lat, m, h, i, r);
    total++;
    if ({m, h, i} !== {4'b0110, 1'b1, 2'd1}) begin
      bad++;
      $display("FAIL prio_two got mask=%b hit=%b idx=%0d want 0110 1 1",
               m, h, i);
    end
  endtask

  task automatic test_segment_mode();
    int lat;
    logic [3:0] m;
    logic h, r;
    logic [1:0] i;
    run_query(12, 12, 0, lat, m, h, i, r);
    total++;
    if ({m, h, i} !== {4'b0000, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL seg_bounded got mask=%b hit=%b idx=%0d want 0000 0 0",
               m, h, i);
    end
    wr(0, 0, 0, 10, 10, 1, 0);
    run_query(12, 12, 0, lat, m, h, i, r);
    total++;
    if (m !== 4'b0001) begin
      bad++;
      $display("FAIL seg_infinite got mask=%b want 0001", m);
    end
  endtask

  task automatic test_disabled();
    int lat;
    logic [3:0] m;
    logic h, r;
    logic [1:0] i;
    wr(3, 0, 0, 31, 31, 0, 1);
    run_query(7, 7, 0, lat, m, h, i, r);
    total++;
    if (m !== 4'b0001) begin
      bad++;
      $display("FAIL disabled got mask=%b want 0001", m);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [3:0] m0;
    logic [1:0] i0;
    bus.in_r_ready = 1'b0;
    accept_query(5, 5);
    n = 0;
    while (!bus.out_r_valid && n < 20) begin
      step();
      n++;
    end
    m0 = bus.out_r_mask;
    i0 = bus.out_r_idx;
    total++;
    if ({m0, i0} !== {4'b0001, 2'd0}) begin
      bad++;
      $display("FAIL bp_result got mask=%b idx=%0d want 0001 0", m0, i0);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if ({bus.out_r_valid, bus.out_q_ready, bus.out_r_mask,
           bus.out_r_idx} !== {1'b1, 1'b0, m0, i0}) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b mask=%b idx=%0d want 1 0 %b %0d",
                 c, bus.out_r_valid, bus.out_q_ready, bus.out_r_mask,
                 bus.out_r_idx, m0, i0);
      end
    end
    bus.in_r_ready = 1'b1;
    step();
    total++;
    if ({bus.out_q_ready, bus.out_r_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release got rdy=%b vld=%b want 1 0",
               bus.out_q_ready, bus.out_r_valid);
    end
  endtask

  task automatic test_collision();
    int n;
    bus.in_r_ready = 1'b1;
    // Write ahead of the scan pointer: must be seen.
    accept_query(20, 5);
    step();
    total++;
    if ({bus.out_det_bx, bus.out_det_by, bus.out_det_ax} !==
        {5'd20, 5'd5, 5'd2}) begin
      bad++;
      $display("FAIL coll_det got bx=%0d by=%0d ax=%0d want 20 5 2",
               bus.out_det_bx, bus.out_det_by, bus.out_det_ax);
    end
    drive_wr(3, 20, 0, 20, 31, 1, 1);
    step();
    bus.in_wr_en = 1'b0;
    model_wr(3, 20, 0, 20, 31, 1, 1);
    n = 0;
    while (!bus.out_r_valid && n < 20) begin
      step();
      n++;
    end
    total++;
    if ({n, bus.out_r_mask, bus.out_r_idx} !== {32'd2, 4'b1000, 2'd3}) begin
      bad++;
      $display("FAIL coll_ahead got wait=%0d mask=%b idx=%0d want 2 1000 3",
               n, bus.out_r_mask, bus.out_r_idx);
    end
    step();
    // Write to the entry under scan: old content is used.
    accept_query(4, 3);
    step();
    drive_wr(1, 0, 10, 31, 10, 1, 1);
    step();
    bus.in_wr_en = 1'b0;
    model_wr(1, 0, 10, 31, 10, 1, 1);
    n = 0;
    while (!bus.out_r_valid && n < 20) begin
      step();
      n++;
    end
    total++;
    if (bus.out_r_mask !== 4'b0110) begin
      bad++;
      $display("FAIL coll_same got mask=%b want 0110", bus.out_r_mask);
    end
    step();
    accept_query(4, 3);
    n = 0;
    while (!bus.out_r_valid && n < 20) begin
      step();
      n++;
    end
    total++;
    if ({bus.out_r_mask, bus.out_r_idx} !== {4'b0100, 2'd2}) begin
      bad++;
      $display("FAIL coll_after got mask=%b idx=%0d want 0100 2",
               bus.out_r_mask, bus.out_r_idx);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    logic [3:0] m;
    logic h, r;
    logic [1:0] i;
    bus.in_r_ready = 1'b1;
    accept_query(4, 3);
    step();
    step();
    rst = 1'b1;
    #1;
    total++;
    if ({bus.out_q_ready, bus.out_r_valid, bus.out_r_mask} !==
        6'b1_0_0000) begin
      bad++;
      $display("FAIL abort_immediate got rdy=%b vld=%b mask=%b want 1 0 0000",
               bus.out_q_ready, bus.out_r_valid, bus.out_r_mask);
    end
    step();
    rst = 1'b0;
    model_clear();
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.out_r_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_no_result got %0d valid cycles want 0", seen);
    end
    run_query(4, 3, 0, lat, m, h, i, r);
    total++;
    if ({lat, m, h} !== {32'd4, 4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL abort_cleared_a got lat=%0d mask=%b hit=%b want 4 0000 0",
               lat, m, h);
    end
    run_query(5, 5, 0, lat, m, h, i, r);
    total++;
    if (m !== 4'b0000) begin
      bad++;
      $display("FAIL abort_cleared_b got mask=%b want 0000", m);
    end
  endtask

  task automatic test_random();
    int lat, k, x, y, sel;
    logic [3:0] m, em;
    logic h, r;
    logic [1:0] i;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        wr($urandom_range(0, 3), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 1)));
      end
      k   = $urandom_range(0, 3);
      sel = $urandom_range(0, 3);
      unique case (sel)
        0: begin x = m_tbl[k].ax; y = m_tbl[k].ay; end
        1: begin x = m_tbl[k].cx; y = m_tbl[k].cy; end
        2: begin
          x = (m_tbl[k].ax + m_tbl[k].cx) / 2;
          y = (m_tbl[k].ay + m_tbl[k].cy) / 2;
        end
        default: begin
          x = $urandom_range(0, 31);
          y = $urandom_range(0, 31);
        end
      endcase
      em = model_mask(x, y);
      run_query(x, y, $urandom_range(0, 2), lat, m, h, i, r);
      total++;
      if ({lat, m, h, i, r} !==
          {32'd4, em, |em, lowest(em), 1'b1}) begin
        bad++;
        $display("FAIL rand it=%0d q=(%0d,%0d) got lat=%0d mask=%b hit=%b idx=%0d rdy=%b want 4 %b %b %0d 1",
                 it, x, y, lat, m, h, i, r, em, |em, lowest(em));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.in_wr_en      = 1'b0;
    bus.in_wr_idx     = '0;
    bus.in_wr_ax      = '0;
    bus.in_wr_ay      = '0;
    bus.in_wr_cx      = '0;
    bus.in_wr_cy      = '0;
    bus.in_wr_enable  = 1'b0;
    bus.in_wr_segment = 1'b0;
    bus.in_q_valid    = 1'b0;
    bus.in_q_x        = '0;
    bus.in_q_y        = '0;
    bus.in_r_ready    = 1'b1;
    model_clear();
    #2;
    test_reset();
    test_single_hit();
    test_priority();
    test_segment_mode();
    test_disabled();
    test_backpressure();
    test_collision();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
